// File: rtl/remote_bus_pkg.sv
// Shared definitions for the multi-core remote bus arbiter: FSM state encodings,
// the default output-port address and the round-robin grant search.
package remote_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  localparam logic [15:0] DEFAULT_OUT_ADDR = 16'hFFFF;

  // First requester after 'last', wrapping modulo n; returns 'last' when nothing is pending.
  function automatic logic [3:0] rr_next_grant(input logic [15:0] req, input logic [3:0] last,
                                               input int n);
    logic [3:0] g;
    logic       found;
    int         idx;
    g     = last;
    found = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      idx = (int'(last) + k) % n;
      if (k <= n && !found && req[idx]) begin
        g     = 4'(idx);
        found = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/remote_out_fifo.sv
// Synchronous first-word-fall-through FIFO for the memory-mapped output channel.
// The caller never pushes when full without popping, and never pops when empty.
module remote_out_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/remote_bus_arbiter.sv
// Round-robin arbiter of NUM_CORES remote ports onto one shared memory port, one access
// in flight. Define OUTPUT_PORT_EN to divert writes to OUT_ADDR into an output FIFO.
module remote_bus_arbiter
  import remote_bus_pkg::*;
#(
  parameter int                    NUM_CORES      = 4,
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    DATA_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] OUT_ADDR       = ADDR_WIDTH'(DEFAULT_OUT_ADDR),
  parameter int                    OUT_FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CORES-1:0]            core_wren,
  input  logic [NUM_CORES-1:0]            core_rden,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] core_write_val,
  output logic [NUM_CORES-1:0]            core_ready,
  output logic [DATA_WIDTH-1:0]           core_read_val,
  output logic                            mem_wren,
  output logic                            mem_rden,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_write_val,
  input  logic [DATA_WIDTH-1:0]           mem_read_val,
  input  logic                            mem_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [$clog2(NUM_CORES)-1:0]    out_core
);

  localparam int CW = $clog2(NUM_CORES);

  arb_state_e            state;
  logic [CW-1:0]         last_grant;
  logic                  op_write;
  logic                  op_out;
  logic [NUM_CORES-1:0]  req;
  logic [CW-1:0]         next_g;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_out;
  logic                  busy_done;

  assign req      = core_wren | core_rden;
  assign next_g   = CW'(rr_next_grant(16'(req), 4'(last_grant), NUM_CORES));
  assign sel_addr = core_addr[next_g*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data = core_write_val[next_g*DATA_WIDTH +: DATA_WIDTH];

`ifdef OUTPUT_PORT_EN
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  assign pop       = out_ready && !fifo_empty;
  // A full FIFO still accepts the push when the head leaves on the same edge.
  assign push      = (state == ARB_BUSY) && op_out && (!fifo_full || pop);
  assign busy_done = op_out ? push : mem_ready;
  assign sel_out   = core_wren[next_g] && (sel_addr == OUT_ADDR);
  assign out_valid = !fifo_empty;

  remote_out_fifo #(
    .WIDTH(DATA_WIDTH + CW),
    .DEPTH(OUT_FIFO_DEPTH)
  ) u_out_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  ({last_grant, mem_write_val}),
    .dout ({out_core, out_data}),
    .full (fifo_full),
    .empty(fifo_empty)
  );
`else
  logic unused_sink;

  assign busy_done   = mem_ready;
  assign sel_out     = 1'b0;
  assign out_valid   = 1'b0;
  assign out_data    = '0;
  assign out_core    = '0;
  assign unused_sink = ^{out_ready, op_out};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ARB_IDLE;
      last_grant    <= CW'(NUM_CORES - 1);
      op_write      <= 1'b0;
      op_out        <= 1'b0;
      core_ready    <= '0;
      core_read_val <= '0;
      mem_wren      <= 1'b0;
      mem_rden      <= 1'b0;
      mem_addr      <= '0;
      mem_write_val <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|req) begin
            last_grant    <= next_g;
            op_write      <= core_wren[next_g];
            op_out        <= sel_out;
            mem_addr      <= sel_addr;
            mem_write_val <= sel_data;
            // A write wins over a simultaneous read from the same core.
            mem_wren      <= core_wren[next_g] && !sel_out;
            mem_rden      <= !core_wren[next_g];
            state         <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (busy_done) begin
            mem_wren               <= 1'b0;
            mem_rden               <= 1'b0;
            if (!op_write) core_read_val <= mem_read_val;
            core_ready[last_grant] <= 1'b1;
            state                  <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          core_ready <= '0;
          state      <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_remote_bus_arbiter.sv
// Directed self-checking bench for remote_bus_arbiter (4 cores, 16-bit address/data).
module tb_remote_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  core_wren;
  logic [3:0]  core_rden;
  logic [63:0] core_addr;
  logic [63:0] core_write_val;
  logic [3:0]  core_ready;
  logic [15:0] core_read_val;
  logic        mem_wren;
  logic        mem_rden;
  logic [15:0] mem_addr;
  logic [15:0] mem_write_val;
  logic [15:0] mem_read_val;
  logic        mem_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_core;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  remote_bus_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .core_wren     (core_wren),
    .core_rden     (core_rden),
    .core_addr     (core_addr),
    .core_write_val(core_write_val),
    .core_ready    (core_ready),
    .core_read_val (core_read_val),
    .mem_wren      (mem_wren),
    .mem_rden      (mem_rden),
    .mem_addr      (mem_addr),
    .mem_write_val (mem_write_val),
    .mem_read_val  (mem_read_val),
    .mem_ready     (mem_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_core      (out_core)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic set_req(input int c, input logic wr, input logic rd, input logic [15:0] addr,
                         input logic [15:0] data);
    core_wren[c]            = wr;
    core_rden[c]            = rd;
    core_addr[c*16 +: 16]   = addr;
    core_write_val[c*16 +: 16] = data;
  endtask

  // Starting one edge before the grant, with mem_ready high: grant, complete, release.
  task automatic txn(input int c, input logic [15:0] addr, input logic ew, input logic er,
                     input logic [15:0] rdata);
    mem_read_val = rdata;
    tick();
    chk("busy_addr", 32'(mem_addr), 32'(addr));
    chk("busy_wren", 32'(mem_wren), 32'(ew));
    chk("busy_rden", 32'(mem_rden), 32'(er));
    chk("busy_noready", 32'(core_ready), 32'd0);
    tick();
    chk("done_ready", 32'(core_ready), 32'd1 << c);
    chk("done_wren", 32'(mem_wren), 32'd0);
    if (er) chk("done_rdata", 32'(core_read_val), 32'(rdata));
    core_wren[c] = 1'b0;
    core_rden[c] = 1'b0;
    tick();
    chk("idle_ready", 32'(core_ready), 32'd0);
    $display("txn core=%0d addr=%h wren=%0d rden=%0d rdata=%h", c, addr, ew, er, rdata);
  endtask

  initial begin
    reset          = 1'b1;
    core_wren      = '0;
    core_rden      = '0;
    core_addr      = '0;
    core_write_val = '0;
    mem_read_val   = '0;
    mem_ready      = 1'b1;
    out_ready      = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(core_ready), 32'd0);
    chk("rst_wren", 32'(mem_wren), 32'd0);
    chk("rst_rden", 32'(mem_rden), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_rval", 32'(core_read_val), 32'd0);
    chk("rst_outv", 32'(out_valid), 32'd0);
    reset = 1'b0;
    tick();

    // All four cores read together from reset: order 0,1,2,3.
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b1, 16'h0100 + 16'(i), 16'h0);
    txn(0, 16'h0100, 1'b0, 1'b1, 16'hA000);
    txn(1, 16'h0101, 1'b0, 1'b1, 16'hA001);
    txn(2, 16'h0102, 1'b0, 1'b1, 16'hA002);
    txn(3, 16'h0103, 1'b0, 1'b1, 16'hA003);

    // Make core 1 the last grantee, then all four again: order 2,3,0,1.
    set_req(1, 1'b0, 1'b1, 16'h0201, 16'h0);
    txn(1, 16'h0201, 1'b0, 1'b1, 16'hB001);
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b1, 16'h0300 + 16'(i), 16'h0);
    txn(2, 16'h0302, 1'b0, 1'b1, 16'hC002);
    txn(3, 16'h0303, 1'b0, 1'b1, 16'hC003);
    txn(0, 16'h0300, 1'b0, 1'b1, 16'hC000);
    txn(1, 16'h0301, 1'b0, 1'b1, 16'hC001);

    // Single-core read, cycle-exact.
    set_req(2, 1'b0, 1'b1, 16'h0010, 16'h0);
    txn(2, 16'h0010, 1'b0, 1'b1, 16'h1234);

    // Write stalled by mem_ready low for 5 cycles.
    mem_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 16'h0040, 16'hBEEF);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_wren", 32'(mem_wren), 32'd1);
      chk("stall_addr", 32'(mem_addr), 32'h0040);
      chk("stall_data", 32'(mem_write_val), 32'hBEEF);
      chk("stall_noready", 32'(core_ready), 32'd0);
      if (i < 4) tick();
    end
    mem_ready = 1'b1;
    tick();
    chk("stall_ready", 32'(core_ready), 32'd1);
    chk("stall_wren_off", 32'(mem_wren), 32'd0);
    core_wren[0] = 1'b0;
    tick();
    $display("txn core=0 addr=0040 stalled write done");

    // wren and rden together from core 3: treated as a write.
    set_req(3, 1'b1, 1'b1, 16'h0077, 16'h5555);
    txn(3, 16'h0077, 1'b1, 1'b0, 16'h0);

    // Reset in BUSY aborts silently; core 0 then wins first.
    set_req(2, 1'b0, 1'b1, 16'h0022, 16'h0);
    mem_read_val = 16'h9999;
    tick();
    chk("pre_rst_busy", 32'(mem_rden), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_rden", 32'(mem_rden), 32'd0);
    chk("arst_addr", 32'(mem_addr), 32'd0);
    chk("arst_rval", 32'(core_read_val), 32'd0);
    chk("arst_ready", 32'(core_ready), 32'd0);
    tick();
    reset = 1'b0;
    set_req(0, 1'b0, 1'b1, 16'h0020, 16'h0);
    txn(0, 16'h0020, 1'b0, 1'b1, 16'h4321);
    txn(2, 16'h0022, 1'b0, 1'b1, 16'h8765);

`ifdef OUTPUT_PORT_EN
    // Output-port write: diverted to the FIFO, never to memory.
    out_ready = 1'b1;
    set_req(1, 1'b1, 1'b0, 16'hFFFF, 16'h00AB);
    tick();
    chk("out_nowren", 32'(mem_wren), 32'd0);
    tick();
    chk("out_ready1", 32'(core_ready), 32'd2);
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_data", 32'(out_data), 32'h00AB);
    chk("out_core", 32'(out_core), 32'd1);
    core_wren[1] = 1'b0;
    tick();
    chk("out_drained", 32'(out_valid), 32'd0);
    $display("txn core=1 addr=ffff out write");

    // Nine writes with the consumer stalled: the ninth backpressures.
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      set_req(0, 1'b1, 1'b0, 16'hFFFF, 16'h0D00 + 16'(k));
      txn(0, 16'hFFFF, 1'b0, 1'b0, 16'h0);
    end
    set_req(0, 1'b1, 1'b0, 16'hFFFF, 16'h0D08);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp_noready", 32'(core_ready), 32'd0);
      chk("bp_nowren", 32'(mem_wren), 32'd0);
      tick();
    end
    chk("bp_head", 32'(out_data), 32'h0D00);
    out_ready = 1'b1;
    tick();
    chk("bp_ready", 32'(core_ready), 32'd1);
    core_wren[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk("pop_valid", 32'(out_valid), 32'd1);
      chk("pop_data", 32'(out_data), 32'h0D00 + 32'(k));
      tick();
    end
    chk("pop_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    $display("txn core=0 nine out writes drained");
`else
    // Without the output channel, OUT_ADDR is ordinary memory.
    out_ready = 1'b1;
    set_req(1, 1'b1, 1'b0, 16'hFFFF, 16'h00AB);
    txn(1, 16'hFFFF, 1'b1, 1'b0, 16'h0);
    chk("plain_outv", 32'(out_valid), 32'd0);
    chk("plain_outd", 32'(out_data), 32'd0);
    out_ready = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
